// File: rtl/pocket_video_formatter.sv
// pocket_video_formatter
//   Converts the LCD-stage raster (clk_vid domain, qualified by ce_pix) into
//   the Pocket scaler video bus. It produces single-period hs/vs strobes, de,
//   gated rgb, and a slot word after each active line. It also measures the
//   active geometry of every frame.
// Ports
//   clk_vid, reset_n             video clock, async active-low reset
//   ce_pix                       pixel enable; state advances only here
//   hs_in, vs_in, hbl_in, vbl_in sync / blank levels from the LCD stage
//   rgb_in[23:0], slot[2:0]      pixel data, scaler slot index
//   video_hs, video_vs           one-period sync strobes
//   video_de, video_rgb[23:0]    data enable, gated pixel / slot word
//   frame_cnt[15:0]              completed frames (wraps)
//   last_width, last_height[8:0] geometry of the previous frame
//   geom_ok                      previous frame matched EXP_W x EXP_H
module pocket_video_formatter #(
  parameter int EXP_W  = 160,
  parameter int EXP_H  = 144,
  parameter int HS_GAP = 3
) (
  input  logic        clk_vid,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        hbl_in,
  input  logic        vbl_in,
  input  logic [23:0] rgb_in,
  input  logic [2:0]  slot,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic [15:0] frame_cnt,
  output logic [8:0]  last_width,
  output logic [8:0]  last_height,
  output logic        geom_ok
);

  localparam int             GW      = (HS_GAP < 1) ? 1 : $clog2(HS_GAP + 1);
  localparam logic [GW-1:0]  GAP_MAX = GW'(HS_GAP);
  localparam logic [8:0]     CNT_MAX = 9'd511;

  // Edge-detect history and control state
  logic          hs_prev_q, vs_prev_q, de_prev_q;
  logic          hs_pend_q;
  logic [GW-1:0] gap_q, gap_d;
  logic [8:0]    x_cnt_q, x_cnt_d;
  logic [8:0]    y_cnt_q, y_cnt_d;
  logic [8:0]    line_w_q;

  // Registered outputs
  logic          video_hs_q, video_vs_q, video_de_q, geom_ok_q;
  logic [23:0]   video_rgb_q;
  logic [15:0]   frame_cnt_q;
  logic [8:0]    last_width_q, last_height_q;

  logic de, vs_rise, hs_rise, de_rise, de_fall, hs_req, hs_fire;

  always_comb begin
    de      = ~hbl_in & ~vbl_in;
    vs_rise = vs_in & ~vs_prev_q;
    hs_rise = hs_in & ~hs_prev_q;
    de_rise = de & ~de_prev_q;
    de_fall = ~de & de_prev_q;

    // Periods since the last vs strobe, saturating; the hs decision uses the
    // value this period will hold so hs lands exactly HS_GAP periods after vs.
    gap_d = gap_q;
    if (vs_rise)
      gap_d = '0;
    else if (gap_q < GAP_MAX)
      gap_d = gap_q + 1'b1;

    // A fresh rise and a pending one collapse into a single request.
    hs_req  = hs_rise | hs_pend_q;
    hs_fire = hs_req & ~vs_rise & (gap_d >= GAP_MAX);

    // x_cnt includes the current pixel, so at the de fall it equals the width.
    x_cnt_d = x_cnt_q;
    if (de_rise)
      x_cnt_d = 9'd1;
    else if (de && x_cnt_q != CNT_MAX)
      x_cnt_d = x_cnt_q + 9'd1;

    // vs clears the line count first; a same-period de rise is line one.
    y_cnt_d = y_cnt_q;
    if (vs_rise)
      y_cnt_d = {8'd0, de_rise};
    else if (de_rise && y_cnt_q != CNT_MAX)
      y_cnt_d = y_cnt_q + 9'd1;
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      de_prev_q     <= 1'b0;
      hs_pend_q     <= 1'b0;
      gap_q         <= GAP_MAX;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      line_w_q      <= '0;
      video_hs_q    <= 1'b0;
      video_vs_q    <= 1'b0;
      video_de_q    <= 1'b0;
      video_rgb_q   <= '0;
      frame_cnt_q   <= '0;
      last_width_q  <= '0;
      last_height_q <= '0;
      geom_ok_q     <= 1'b0;
    end else if (ce_pix) begin
      hs_prev_q  <= hs_in;
      vs_prev_q  <= vs_in;
      de_prev_q  <= de;
      gap_q      <= gap_d;
      hs_pend_q  <= hs_req & ~hs_fire;
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;

      video_hs_q <= hs_fire;
      video_vs_q <= vs_rise;
      video_de_q <= de;

      // The slot word marks end of line only; a fall caused by vbl alone
      // (hbl still low) is the end of the frame and carries no slot.
      if (de)
        video_rgb_q <= rgb_in;
      else if (de_fall && hbl_in)
        video_rgb_q <= {21'd0, slot};
      else
        video_rgb_q <= '0;

      if (de_fall)
        line_w_q <= x_cnt_q;

      // Geometry is published from the counters as they stood before this period.
      if (vs_rise) begin
        last_width_q  <= line_w_q;
        last_height_q <= y_cnt_q;
        geom_ok_q     <= (line_w_q == 9'(EXP_W)) && (y_cnt_q == 9'(EXP_H));
        frame_cnt_q   <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign video_hs    = video_hs_q;
  assign video_vs    = video_vs_q;
  assign video_de    = video_de_q;
  assign video_rgb   = video_rgb_q;
  assign frame_cnt   = frame_cnt_q;
  assign last_width  = last_width_q;
  assign last_height = last_height_q;
  assign geom_ok     = geom_ok_q;

endmodule

// File: tb/tb_pocket_video_formatter.sv
// Testbench for pocket_video_formatter. Randomised raster plus level fuzzing
// is scored against a behavioural reference model through an expected queue.
// Geometry is scaled down (W x H) so several full frames fit in a short run.
module tb_pocket_video_formatter;

  localparam int W   = 40;
  localparam int H   = 24;
  localparam int GAP = 3;

  logic        clk_vid = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pix  = 1'b0;
  logic        hs_in   = 1'b0;
  logic        vs_in   = 1'b0;
  logic        hbl_in  = 1'b0;
  logic        vbl_in  = 1'b0;
  logic [23:0] rgb_in  = '0;
  logic [2:0]  slot    = '0;
  logic        video_hs, video_vs, video_de, geom_ok;
  logic [23:0] video_rgb;
  logic [15:0] frame_cnt;
  logic [8:0]  last_width, last_height;

  pocket_video_formatter #(.EXP_W(W), .EXP_H(H), .HS_GAP(GAP)) dut (
    .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix),
    .hs_in(hs_in), .vs_in(vs_in), .hbl_in(hbl_in), .vbl_in(vbl_in),
    .rgb_in(rgb_in), .slot(slot),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
    .video_rgb(video_rgb), .frame_cnt(frame_cnt),
    .last_width(last_width), .last_height(last_height), .geom_ok(geom_ok)
  );

  always #5 clk_vid = ~clk_vid;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic [15:0] fc;
    logic [8:0]  lw;
    logic [8:0]  lh;
    logic        ok;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: plain counts of events since reset.
  bit m_phs, m_pvs, m_pde, m_want;
  int m_since, m_px, m_line_w, m_lines, m_frames, m_last_w, m_last_h;
  bit m_ok;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    m_phs = 0; m_pvs = 0; m_pde = 0; m_want = 0;
    m_since = GAP; m_px = 0; m_line_w = 0; m_lines = 0;
    m_frames = 0; m_last_w = 0; m_last_h = 0; m_ok = 0;
  endfunction

  function automatic out_t cur_out();
    return {video_hs, video_vs, video_de, video_rgb, frame_cnt,
            last_width, last_height, geom_ok};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One pixel period with the given levels, followed by 0..2 idle clocks
  // during which the inputs wander (the DUT must ignore them).
  task automatic step(input logic h, input logic v, input logic hb, input logic vb);
    out_t        e;
    bit          de, vr, hr;
    logic [23:0] r;
    logic [2:0]  s;
    int          idle;
    r = 24'($urandom);
    s = 3'($urandom);
    @(negedge clk_vid);
    hs_in = h; vs_in = v; hbl_in = hb; vbl_in = vb;
    rgb_in = r; slot = s; ce_pix = 1'b1;

    de = !hb && !vb;
    vr = v && !m_pvs;
    hr = h && !m_phs;
    m_since = vr ? 0 : imin(m_since + 1, 1000);
    if (hr) m_want = 1;
    e.hs = m_want && (m_since >= GAP);
    if (e.hs) m_want = 0;
    e.vs = vr;
    e.de = de;
    e.rgb = de ? r : ((m_pde && !de && hb) ? {21'd0, s} : 24'd0);
    if (vr) begin
      m_last_w = m_line_w;
      m_last_h = imin(m_lines, 511);
      m_ok     = (m_last_w == W) && (m_last_h == H);
      m_frames = (m_frames + 1) % 65536;
      m_lines  = 0;
    end
    if (de && !m_pde) begin m_lines++; m_px = 0; end
    if (de) m_px++;
    if (!de && m_pde) m_line_w = imin(m_px, 511);
    e.fc = 16'(m_frames);
    e.lw = 9'(m_last_w);
    e.lh = 9'(m_last_h);
    e.ok = m_ok;
    m_phs = h; m_pvs = v; m_pde = de;
    exp_q.push_back(e);

    idle = $urandom_range(0, 2);
    repeat (idle) begin
      @(negedge clk_vid);
      ce_pix = 1'b0;
      {hs_in, vs_in, hbl_in, vbl_in} = 4'($urandom);
      rgb_in = 24'($urandom);
      slot = 3'($urandom);
    end
  endtask

  // Stop issuing pixels and let the last one reach the outputs.
  task automatic quiet();
    @(negedge clk_vid);
    ce_pix = 1'b0;
    #1;
  endtask

  task automatic line(input int w, input int blank);
    for (int i = 0; i < w; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < blank; j++) step(j == 1 || j == 2, 1'b0, 1'b1, 1'b0);
  endtask

  // hs and vs rise together on the first period of vertical blank.
  task automatic vsync(input logic hb);
    for (int j = 0; j < 8; j++) step(j < 2, j < 3, hb, 1'b1);
  endtask

  task automatic frame(input int last_w);
    for (int l = 0; l < H; l++) line((l == H - 1) ? last_w : W, 6);
  endtask

  // Monitor: pops one expectation per sampled ce_pix; outputs must hold
  // that value until the next one, and read zero while in reset.
  initial begin
    out_t last;
    bit   ce_s;
    last = '0;
    forever begin
      @(posedge clk_vid);
      ce_s = ce_pix && reset_n;
      @(negedge clk_vid);
      if (!reset_n) begin
        last = '0;
      end else if (ce_s) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_underflow actual=empty required=entry");
        end else begin
          last = exp_q.pop_front();
        end
      end
      checks++;
      if (cur_out() !== last) begin
        errors++;
        $display("FAIL out_cmp t=%0t actual=%h required=%h (hs,vs,de,rgb,fc,lw,lh,ok)",
                 $time, cur_out(), last);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f_hs, f_vs, f_hb, f_vb;
    model_reset();
    repeat (3) @(negedge clk_vid);
    #2 reset_n = 1'b1;
    quiet();
    chk("reset_state", 64'(cur_out()), 64'd0);

    // Nominal frames
    vsync(1'b1); quiet();
    chk("first_vs_fc", frame_cnt, 1);
    chk("first_vs_lh", last_height, 0);
    chk("first_vs_ok", geom_ok, 0);
    frame(W); vsync(1'b1); quiet();
    chk("nom_fc", frame_cnt, 2);
    chk("nom_lw", last_width, W);
    chk("nom_lh", last_height, H);
    chk("nom_ok", geom_ok, 1);
    frame(W); vsync(1'b1); quiet();
    chk("nom2_fc", frame_cnt, 3);

    // Short last line, then restored
    frame(W - 1); vsync(1'b1); quiet();
    chk("short_lw", last_width, W - 1);
    chk("short_ok", geom_ok, 0);
    frame(W); vsync(1'b1); quiet();
    chk("restore_lw", last_width, W);
    chk("restore_ok", geom_ok, 1);

    // Overlong line saturates the width counter
    line(600, 6); vsync(1'b1); quiet();
    chk("sat_lw", last_width, 511);
    chk("sat_lh", last_height, 1);
    chk("sat_ok", geom_ok, 0);

    // Random level fuzzing (merged hs, pending hs, odd blank patterns)
    f_hs = 0; f_vs = 0; f_hb = 1; f_vb = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) f_hs = ~f_hs;
      if ($urandom_range(0, 9) == 0) f_vs = ~f_vs;
      if ($urandom_range(0, 4) == 0) f_hb = ~f_hb;
      if ($urandom_range(0, 19) == 0) f_vb = ~f_vb;
      step(f_hs, f_vs, f_hb, f_vb);
    end
    vsync(1'b1); quiet();

    // Reset in the middle of an active line
    line(10, 0); quiet();
    #2 reset_n = 1'b0;
    #1 chk("async_reset_out", 64'(cur_out()), 64'd0);
    repeat (2) @(posedge clk_vid);
    @(negedge clk_vid);
    #2 reset_n = 1'b1;
    model_reset();
    line(W - 10, 0);
    vsync(1'b0); quiet();   // vbl-only de fall: no slot word
    chk("post_reset_fc", frame_cnt, 1);
    chk("post_reset_lh", last_height, 1);
    frame(W); vsync(1'b1); quiet();
    chk("post_reset_fc2", frame_cnt, 2);
    chk("post_reset_ok", geom_ok, 1);

    quiet();
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
